// File: rtl/score_keeper.sv
// score_keeper: turns de-duplicated coin/police hit pulses into score, lives, best score and game phase.
// Ports: CLOCK_50 clock; reset async active-high; EnterEn start/restart; CoinEn/PoliceEn hit pulses;
//        score/best_score/lives counters; Playing/GameOver phase flags; CrashFlash police blanking active.
module score_keeper #(
  parameter int SCORE_W      = 10,
  parameter int LIVES_W      = 2,
  parameter int START_LIVES  = 3,
  parameter int COIN_VALUE   = 1,
  parameter int BLANK_CYCLES = 25000000,
  parameter int BLANK_W      = 25
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               EnterEn,
  input  logic               CoinEn,
  input  logic               PoliceEn,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score,
  output logic [LIVES_W-1:0] lives,
  output logic               Playing,
  output logic               GameOver,
  output logic               CrashFlash
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
  state_t             state, st_n;
  logic [SCORE_W-1:0] score_n, best_n;
  logic [SCORE_W:0]   sum;
  logic [LIVES_W-1:0] lives_n;
  logic [BLANK_W-1:0] coin_blank, police_blank, cb_n, pb_n;
  logic               coin_ok, pol_ok;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state        <= IDLE;
      score        <= '0;
      best_score   <= '0;
      lives        <= LIVES_INIT;
      coin_blank   <= '0;
      police_blank <= '0;
      Playing      <= 1'b0;
      GameOver     <= 1'b0;
      CrashFlash   <= 1'b0;
    end else begin
      state        <= st_n;
      score        <= score_n;
      best_score   <= best_n;
      lives        <= lives_n;
      coin_blank   <= cb_n;
      police_blank <= pb_n;
      Playing      <= st_n == PLAY;
      GameOver     <= st_n == OVER;
      CrashFlash   <= st_n == PLAY && pb_n != '0;
    end
  always_comb begin
    sum     = {1'b0, score} + (SCORE_W+1)'(COIN_VALUE);
    coin_ok = CoinEn && coin_blank == '0;
    pol_ok  = PoliceEn && police_blank == '0;
    st_n    = state;
    score_n = score;
    best_n  = best_score;
    lives_n = lives;
    cb_n    = coin_blank == '0 ? '0 : coin_blank - BLANK_W'(1);
    pb_n    = police_blank == '0 ? '0 : police_blank - BLANK_W'(1);
    case (state)
      IDLE: begin
        score_n = '0;
        lives_n = LIVES_INIT;
        cb_n    = '0;
        pb_n    = '0;
        st_n    = EnterEn ? PLAY : IDLE;
      end
      PLAY:
        // a fatal hit wins over a simultaneous coin so the captured best is the pre-coin score
        if (pol_ok && lives <= LIVES_W'(1)) begin
          st_n    = OVER;
          lives_n = '0;
          best_n  = score > best_score ? score : best_score;
          cb_n    = '0;
          pb_n    = '0;
        end else begin
          if (coin_ok) begin
            score_n = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
            cb_n    = BLANK_LOAD;
          end
          if (pol_ok) begin
            lives_n = lives - LIVES_W'(1);
            pb_n    = BLANK_LOAD;
          end
        end
      OVER: begin
        lives_n = '0;
        cb_n    = '0;
        pb_n    = '0;
        if (EnterEn) begin
          st_n    = PLAY;
          score_n = '0;
          lives_n = LIVES_INIT;
        end
      end
      default: begin
        st_n    = IDLE;
        score_n = '0;
        lives_n = LIVES_INIT;
        cb_n    = '0;
        pb_n    = '0;
      end
    endcase
  end
endmodule
